reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline CPU's 2-read/1-write register file.
- Generalises data width, register count and read-port count.
- Adds synchronous clear, same-cycle write-to-read bypass, and a per-register pending-write scoreboard.
- Sits in ID stage: read ports feed operand latches; scoreboard drives hazard/stall logic; write port driven from WB.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- RegWrite  in  1  write enable (WB stage)
- WN  in  ADDR_W  write register index
- WD  in  DATA_W  write data
- RN  in  NUM_RD*ADDR_W  read indices; port k = RN[k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  read data; port k = RD[k*DATA_W +: DATA_W]
- busy_set  in  1  mark a register pending (instruction issued with a destination)
- busy_wn  in  ADDR_W  register to mark pending
- busy  out  NUM_RD  per-read-port hazard flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: at posedge clk with rst_n=0, all registers 1..NREGS-1 go to 0 and all scoreboard bits go to 0. RegWrite and busy_set are ignored in that cycle.
- Outputs after reset: RD = 0 for all ports; busy = 0.
- Register 0: reads always 0 and is never busy. Writes to 0 and busy_set with busy_wn=0 are dropped.
- Write: at posedge clk with rst_n=1, RegWrite=1 and WN!=0: file[WN] <= WD. Visible in the array the next cycle.
- Read: combinational, 0-cycle latency, evaluated per port k.
  - RN_k == 0 -> RD_k = 0.
  - Else if RegWrite && WN == RN_k -> RD_k = WD (bypass).
  - Else RD_k = file[RN_k].
- Multiple ports may address the same register. All of them return identical data.
- Scoreboard: one bit per register, updated at posedge clk with rst_n=1.
  - busy_set && busy_wn != 0 -> bit[busy_wn] <= 1.
  - RegWrite && WN != 0 -> bit[WN] <= 0.
  - Same address, same cycle: set wins, because a new producer was issued.
  - Different addresses: both updates apply.
- busy_k = bit[RN_k] & ~(RegWrite && WN == RN_k) & (RN_k != 0). Bypass satisfies the hazard within the cycle.
- Reset mid-operation: any pending writes or busy marks are lost. A write coincident with reset is discarded.
- No X on RD after reset for any legal index.

Optional Feature:
- Macro: REG_FILE_TRACE_EN.
- Defined: $display per accepted write, as "time/10, reg_file[n] <= value (Write)". Also displays per read-port data change, with the port index.
- Undefined: no display statements compiled. Logic identical.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the ZERO_REG index constant (0);
  - the rd_port_t typedef, an ADDR_W-wide index.
- Natural sub-module: reg_scoreboard, holding the busy-bit array plus set/clear priority. It takes clk, rst_n, set/clear indices and enables, and exposes the bit vector.
- Read muxing and bypass stay in the top level, in a generate loop over NUM_RD.

Test Plan:
- Reset with rst_n=0 for 2 cycles after writing 0xDEADBEEF to r5 -> RN0=5 reads 0; busy=0.
- RegWrite=1, WN=7, WD=0x1234, RN0=7 in the same cycle -> RD0=0x1234 combinationally. The following cycle with RegWrite=0 -> RD0 still 0x1234.
- RegWrite=1, WN=0, WD=0xFFFFFFFF; busy_set=1, busy_wn=0 -> RN1=0 gives RD1=0 and busy[1]=0 on all later cycles.
- busy_set at r3 -> next cycle busy[0]=1 for RN0=3. WB cycle with WN=3, WD=9 -> busy[0]=0 and RD0=9 in that cycle; bit cleared the next cycle.
- Same cycle: busy_set r4 and RegWrite WN=4, WD=5 -> next cycle r4 reads 5 and busy=1 (set wins).
- NUM_RD=3, DATA_W=16: all three ports read r9 after writing 0xABCD -> all RD=0xABCD. Ports at 0/9/10 with only r9 busy -> busy=3'b010.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the parametrised register file with scoreboard.
package reg_file_pkg;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    typedef logic [DEFAULT_ADDR_W-1:0] rd_port_t;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear on the same index.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    output logic [NREGS-1:0]  bits
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    // Set is applied after clear so a newly issued producer keeps the register pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits <= '0;
        end else begin
            if (clr_en && clr_idx != ZERO_IDX)
                bits[clr_idx] <= 1'b0;
            if (set_en && set_idx != ZERO_IDX)
                bits[set_idx] <= 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with WB->ID bypass and busy scoreboard.
// Optional write/read tracing under REG_FILE_TRACE_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WN,
    input  logic [DATA_W-1:0]        WD,
    input  logic [NUM_RD*ADDR_W-1:0] RN,
    output logic [NUM_RD*DATA_W-1:0] RD,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_wn,
    output logic [NUM_RD-1:0]        busy
);
    localparam int unsigned       NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  sb_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (RegWrite && WN != ZERO_IDX) begin
            regs[WN] <= WD;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (busy_set),
        .set_idx (busy_wn),
        .clr_en  (RegWrite),
        .clr_idx (WN),
        .bits    (sb_bits)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rn;
        logic              hit;
        logic [DATA_W-1:0] rd;

        assign rn  = RN[k*ADDR_W +: ADDR_W];
        assign hit = RegWrite && (WN == rn);

        always_comb begin
            if (rn == ZERO_IDX)
                rd = '0;
            else if (hit)
                rd = WD;
            else
                rd = regs[rn];
        end

        assign RD[k*DATA_W +: DATA_W] = rd;
        // A value arriving on the bypass this cycle already resolves the hazard.
        assign busy[k] = sb_bits[rn] & ~hit & (rn != ZERO_IDX);
    end

`ifdef REG_FILE_TRACE_EN
    logic [DATA_W-1:0] rd_prev [NUM_RD];

    always_ff @(posedge clk) begin
        if (rst_n && RegWrite && WN != ZERO_IDX)
            $display("%0t, reg_file[%0d] <= %h (Write)", $time / 10, WN, WD);
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (RD[k*DATA_W +: DATA_W] != rd_prev[k])
                $display("%0t, read port %0d data %h", $time / 10, k, RD[k*DATA_W +: DATA_W]);
            rd_prev[k] <= RD[k*DATA_W +: DATA_W];
        end
    end
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: two configurations (32b/2 ports, 16b/3 ports) driven by one stimulus.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n, we, bs;
    logic [4:0]  wn, bwn, rn0, rn1, rn2;
    logic [31:0] wd;

    logic [63:0] rd_a;
    logic [1:0]  busy_a;
    logic [47:0] rd_b;
    logic [2:0]  busy_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [32];
    logic        pend [32];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .RegWrite(we), .WN(wn), .WD(wd),
        .RN({rn1, rn0}), .RD(rd_a), .busy_set(bs), .busy_wn(bwn), .busy(busy_a)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .RegWrite(we), .WN(wn), .WD(wd[15:0]),
        .RN({rn2, rn1, rn0}), .RD(rd_b), .busy_set(bs), .busy_wn(bwn), .busy(busy_b)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] rn);
        if (rn == 0)                 return 32'h0;
        else if (we && wn == rn)     return wd;
        else                         return mem[rn];
    endfunction

    function automatic logic exp_busy(input logic [4:0] rn);
        return (rn != 0) && pend[rn] && !(we && wn == rn);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic w, input logic [4:0] n, input logic [31:0] d,
                          input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                          input logic s, input logic [4:0] sn);
        rst_n = r; we = w; wn = n; wd = d; rn0 = a0; rn1 = a1; rn2 = a2; bs = s; bwn = sn;
    endtask

    // Check outputs against the model, then clock and advance the model.
    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) begin
            chk32("a_rd0",  rd_a[31:0],  exp_rd(rn0));
            chk32("a_rd1",  rd_a[63:32], exp_rd(rn1));
            chk32("a_busy", {30'b0, busy_a}, {30'b0, exp_busy(rn1), exp_busy(rn0)});
            chk32("b_rd0",  {16'b0, rd_b[15:0]},  {16'b0, exp_rd(rn0) & 32'hFFFF});
            chk32("b_rd1",  {16'b0, rd_b[31:16]}, {16'b0, exp_rd(rn1) & 32'hFFFF});
            chk32("b_rd2",  {16'b0, rd_b[47:32]}, {16'b0, exp_rd(rn2) & 32'hFFFF});
            chk32("b_busy", {29'b0, busy_b}, {29'b0, exp_busy(rn2), exp_busy(rn1), exp_busy(rn0)});
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  = 32'h0;
                pend[i] = 1'b0;
            end
        end else begin
            if (we && wn != 0) begin
                mem[wn]  = wd;
                pend[wn] = 1'b0;
            end
            if (bs && bwn != 0)
                pend[bwn] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 32'h0;
            pend[i] = 1'b0;
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0);
        cycle(0);

        // Reset discards earlier write and a write coincident with reset
        set_in(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 1, 6);
        cycle(1);
        set_in(0, 1, 5, 32'h11111111, 0, 0, 0, 1, 5);
        cycle(0);
        cycle(0);
        set_in(1, 0, 0, 0, 5, 6, 5, 0, 0);
        cycle(1);
        chk32("reset_r5", rd_a[31:0], 32'h0);
        chk32("reset_busy", {30'b0, busy_a}, 32'h0);

        // Bypass then registered read
        set_in(1, 1, 7, 32'h1234, 7, 7, 7, 0, 0);
        #1 chk32("bypass_r7", rd_a[31:0], 32'h1234);
        cycle(1);
        set_in(1, 0, 0, 0, 7, 0, 7, 0, 0);
        cycle(1);

        // Register 0 ignores writes and busy marks
        set_in(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        cycle(1);
        set_in(1, 0, 0, 0, 7, 0, 0, 0, 0);
        cycle(1);
        chk32("r0_busy", {31'b0, busy_a[1]}, 32'h0);

        // Busy set, then WB clears with bypass
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 3);
        cycle(1);
        set_in(1, 0, 0, 0, 3, 0, 3, 0, 0);
        #1 chk32("busy_r3", {31'b0, busy_a[0]}, 32'h1);
        cycle(1);
        set_in(1, 1, 3, 9, 3, 0, 3, 0, 0);
        #1 chk32("wb_r3_busy", {31'b0, busy_a[0]}, 32'h0);
        chk32("wb_r3_rd", rd_a[31:0], 32'h9);
        cycle(1);
        set_in(1, 0, 0, 0, 3, 3, 3, 0, 0);
        cycle(1);

        // Same-cycle set and clear on r4: set wins
        set_in(1, 1, 4, 5, 0, 0, 0, 1, 4);
        cycle(1);
        set_in(1, 0, 0, 0, 4, 4, 4, 0, 0);
        #1 chk32("setwin_rd", rd_a[31:0], 32'h5);
        chk32("setwin_busy", {31'b0, busy_a[0]}, 32'h1);
        cycle(1);

        // Three-port narrow instance
        set_in(1, 1, 9, 32'h0000ABCD, 0, 0, 0, 0, 0);
        cycle(1);
        set_in(1, 0, 0, 0, 9, 9, 9, 1, 9);
        #1 chk32("b_all9", {rd_b[47:32] ^ rd_b[31:16], rd_b[15:0]}, 32'h0000ABCD);
        cycle(1);
        set_in(1, 0, 0, 0, 0, 9, 10, 0, 0);
        #1 chk32("b_busy010", {29'b0, busy_b}, 32'h2);
        cycle(1);

        // Randomized phase with occasional reset and biased index collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r0, r1, r2, w, b;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            w  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            b  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r0 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r1 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r2 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            set_in(($urandom_range(0, 31) != 0), 1'($urandom), w, $urandom,
                   r0, r1, r2, 1'($urandom), b);
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
